// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: microword layout,
// branch condition codes, FSM encoding and NOP field values.
package micro_sequencer_pkg;

  localparam int unsigned WORD_W = 29;

  typedef enum logic [1:0] {
    COND_SEQ = 2'b00,
    COND_N   = 2'b01,
    COND_Z   = 2'b10,
    COND_JMP = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_WAIT,
    ST_HALTED
  } state_e;

  // Stage-2 fields; NOP is all zero (C=0 means no register write).
  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sh;
    logic [5:0] c;
    logic [6:0] t;
  } fields_t;

  localparam fields_t NOP_FIELDS = '0;

  // Microword layout, MSB first: [28] halt, [27:26] cond, [25:19] next, [18:0] fields.
  typedef struct packed {
    logic    halt;
    cond_e   cond;
    logic [6:0] next;
    fields_t fields;
  } uword_t;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-microaddress select and stall detection.
module micro_next_addr
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic [ADDR_W-1:0] mpc_i,
  input  cond_e             cond_i,
  input  logic [ADDR_W-1:0] next_i,
  input  logic              flag_n_i,
  input  logic              flag_z_i,
  input  logic              flag_valid_i,
  input  logic              hold_i,
  output logic [ADDR_W-1:0] next_mpc_o,
  output logic              stall_o
);

  logic taken;
  logic hazard;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    taken = 1'b0;
    unique case (cond_i)
      COND_SEQ: taken = 1'b0;
      COND_N:   taken = flag_n_i;
      COND_Z:   taken = flag_z_i;
      COND_JMP: taken = 1'b1;
    endcase
  end

  assign hazard  = ((cond_i == COND_N) || (cond_i == COND_Z)) && !flag_valid_i;
  assign stall_o = hold_i || hazard;

  // Sequential increment wraps naturally at ADDR_W bits.
  assign next_mpc_o = stall_o ? mpc_i
                    : (taken ? next_i : mpc_i + ADDR_W'(1));

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the MPC, drives the control-store address and
// issues one microinstruction per cycle. Optional MICRO_SEQUENCER_STEP_EN adds a `step` input.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              hold,
`ifdef MICRO_SEQUENCER_STEP_EN
  input  logic              step,
`endif
  input  logic              flag_n,
  input  logic              flag_z,
  input  logic              flag_valid,
  output logic [ADDR_W-1:0] cs_addr,
  input  logic [WORD_W-1:0] cs_data,
  output logic [3:0]        alu_out,
  output logic [1:0]        sh_out,
  output logic [5:0]        c_out,
  output logic [6:0]        t_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  fields_t           fields_q, fields_d;
  logic              valid_q, valid_d;

  uword_t            word;
  logic              run_hold;
  logic [ADDR_W-1:0] next_mpc;
  logic              stall;

  assign word = uword_t'(cs_data);

`ifdef MICRO_SEQUENCER_STEP_EN
  // Without a step pulse, RUN behaves exactly as if held.
  assign run_hold = hold || !step;
`else
  assign run_hold = hold;
`endif

  micro_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .mpc_i        (mpc_q),
    .cond_i       (word.cond),
    .next_i       (ADDR_W'(word.next)),
    .flag_n_i     (flag_n),
    .flag_z_i     (flag_z),
    .flag_valid_i (flag_valid),
    .hold_i       (run_hold),
    .next_mpc_o   (next_mpc),
    .stall_o      (stall)
  );

  always_comb begin
    state_d  = state_q;
    mpc_d    = mpc_q;
    cs_addr  = mpc_q;
    fields_d = NOP_FIELDS;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_addr = START;
        if (start) begin
          mpc_d   = START;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_RUN;
      ST_RUN: begin
        // Priority: hold > halt > flag hazard > issue.
        if (run_hold) begin
          state_d = ST_RUN;
        end else if (word.halt) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          state_d = ST_WAIT;
        end else begin
          fields_d = word.fields;
          valid_d  = 1'b1;
          mpc_d    = next_mpc;
          cs_addr  = next_mpc;
        end
      end
      ST_WAIT: begin
        if (flag_valid && !hold) state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (start) begin
          mpc_d   = START;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mpc_q    <= START;
      fields_q <= NOP_FIELDS;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
    end
  end

  assign alu_out   = fields_q.alu;
  assign sh_out    = fields_q.sh;
  assign c_out     = fields_q.c;
  assign t_out     = fields_q.t;
  assign valid_out = valid_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign done      = (state_q == ST_HALTED);

endmodule
